// File: rtl/fp_pkg.sv
// Shared FP adder definitions: field widths, exponent-control codes and limits.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int MANT_W = FRAC_W + 4;

  // Exponent-control codes as produced by the right-path normalising shifter
  localparam logic [1:0] SHIFT_LEFT  = 2'b00;
  localparam logic [1:0] SHIFT_RIGHT = 2'b01;
  localparam logic [1:0] DONT_SHIFT  = 2'b10;

  localparam int EXP_MAX = 255;
  localparam int BIAS    = 127;
endpackage

// File: rtl/round_pack_stage_if.sv
// Upstream/downstream handshake bundle of the round/pack stage.
interface round_pack_stage_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic [EXP_W-1:0]        in_exp;
  logic [FRAC_W+3:0]       in_mant;
  logic [1:0]              in_exp_ctrl;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W:0]   out_result;
  logic                    out_overflow;
  logic                    out_underflow;
  logic                    out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_exp_ctrl, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_exp_ctrl, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/round_pack_stage_rne_round.sv
// Round-to-nearest-even: G/R/S decision and significand increment with carry-out.
module rne_round #(
  parameter int SIG_W = 24
) (
  input  logic             i_lsb,
  input  logic             i_g,
  input  logic             i_r,
  input  logic             i_s,
  output logic             o_round_up,
  output logic             o_inexact,
  input  logic [SIG_W-1:0] i_sig,
  input  logic             i_inc,
  output logic [SIG_W-1:0] o_sig,
  output logic             o_carry
);
  // Decision and increment are separate so a pipeline can register between them
  assign o_round_up = i_g & (i_r | i_s | i_lsb);
  assign o_inexact  = i_g | i_r | i_s;
  assign {o_carry, o_sig} = {1'b0, i_sig} + (SIG_W+1)'(i_inc);
endmodule

// File: rtl/round_pack_stage.sv
// FP adder right-path final stage: exponent update, RNE rounding, range check, pack.
module round_pack_stage
  import fp_pkg::*;
#(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int FRAC_W = fp_pkg::FRAC_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  round_pack_stage_if.slave     bus
);
  localparam int EA_W  = EXP_W + 2;
  localparam int SG_W  = FRAC_W + 1;
  localparam logic signed [EA_W-1:0] EXP_SAT  = EA_W'((1 << EXP_W) - 1);
  localparam logic signed [EA_W-1:0] EXP_ZERO = '0;

  logic                   w_s1_adv, w_s2_adv;
  logic signed [EA_W-1:0] w_exp_ext, w_exp_adj, w_exp_f;
  logic                   w_round_up, w_inexact0, w_carry;
  logic [SG_W-1:0]        w_sum;
  logic [FRAC_W-1:0]      w_frac;
  logic [EXP_W+FRAC_W:0]  w_res;
  logic                   w_ovf, w_unf, w_inx;

  logic                   r1_valid, r1_sign, r1_rup, r1_inx, r1_zero;
  logic signed [EA_W-1:0] r1_exp;
  logic [SG_W-1:0]        r1_sig;
  logic                   r2_valid, r_ovf, r_unf, r_inx;
  logic [EXP_W+FRAC_W:0]  r_result;

  assign w_s2_adv     = !r2_valid || bus.out_ready;
  assign w_s1_adv     = !r1_valid || w_s2_adv;
  assign bus.in_ready = w_s1_adv;

  // Two guard bits of headroom keep 255+1 and 0-1 from wrapping
  assign w_exp_ext = signed'({2'b00, bus.in_exp});
  always_comb begin
    w_exp_adj = w_exp_ext;
    case (bus.in_exp_ctrl)
      SHIFT_LEFT:  w_exp_adj = w_exp_ext - EA_W'(1);
      SHIFT_RIGHT: w_exp_adj = w_exp_ext + EA_W'(1);
      default:     w_exp_adj = w_exp_ext;
    endcase
  end

  rne_round #(.SIG_W(SG_W)) u_rne (
    .i_lsb      (bus.in_mant[3]),
    .i_g        (bus.in_mant[2]),
    .i_r        (bus.in_mant[1]),
    .i_s        (bus.in_mant[0]),
    .o_round_up (w_round_up),
    .o_inexact  (w_inexact0),
    .i_sig      (r1_sig),
    .i_inc      (r1_rup),
    .o_sig      (w_sum),
    .o_carry    (w_carry)
  );

  // Carry-out only happens from all-ones, so the shifted fraction is zero
  assign w_frac  = w_carry ? w_sum[FRAC_W:1] : w_sum[FRAC_W-1:0];
  assign w_exp_f = r1_exp + EA_W'(w_carry);

  always_comb begin
    w_res = {r1_sign, {(EXP_W+FRAC_W){1'b0}}};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inx = 1'b0;
    if (r1_zero) begin
      w_res = {r1_sign, {(EXP_W+FRAC_W){1'b0}}};
    end else if (w_exp_f >= EXP_SAT) begin
      w_res = {r1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      w_ovf = 1'b1;
      w_inx = 1'b1;
    end else if (w_exp_f <= EXP_ZERO) begin
      w_unf = 1'b1;
      w_inx = 1'b1;
    end else begin
      w_res = {r1_sign, w_exp_f[EXP_W-1:0], w_frac};
      w_inx = r1_inx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_inx    <= 1'b0;
    end else begin
      if (w_s1_adv) r1_valid <= bus.in_valid;
      if (w_s2_adv) begin
        r2_valid <= r1_valid;
        if (r1_valid) begin
          r_result <= w_res;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
          r_inx    <= w_inx;
        end
      end
    end
  end

  // Stage-1 payload is qualified by r1_valid and needs no reset
  always_ff @(posedge clk) begin
    if (w_s1_adv && bus.in_valid) begin
      r1_sign <= bus.in_sign;
      r1_exp  <= w_exp_adj;
      r1_sig  <= bus.in_mant[FRAC_W+3:3];
      r1_rup  <= w_round_up;
      r1_inx  <= w_inexact0;
      r1_zero <= (bus.in_mant == '0);
    end
  end

  assign bus.out_valid     = r2_valid;
  assign bus.out_result    = r_result;
  assign bus.out_overflow  = r_ovf;
  assign bus.out_underflow = r_unf;
  assign bus.out_inexact   = r_inx;
endmodule
